serial_subtractor: RTL

//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), plus a borrow flag.

---
 rtl/serial_subtractor.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b mod 2^WIDTH, borrow = a < b).
// One full-subtractor cell processes one bit per clock, LSB first, behind valid/ready.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | shifting one bit per clock through the subtractor cell
// DONE  | result presented, waiting for out_ready
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             bflop;

  logic hs1_d, hs1_b, hs2_d, hs2_b, bnext;
  logic accept, last_bit;

  // Full subtractor built from two half-subtractor stages.
  assign hs1_d = a_sr[0] ^ b_sr[0];
  assign hs1_b = ~a_sr[0] & b_sr[0];
  assign hs2_d = hs1_d ^ bflop;
  assign hs2_b = ~hs1_d & bflop;
  assign bnext = hs1_b | hs2_b;

  assign accept   = (state == S_IDLE) && in_valid;
  assign last_bit = (state == S_BUSY) && (cnt == CNT_LAST);

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
      S_BUSY:  if (last_bit)  state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      busy   <= 1'b1;
    end else if (state == S_BUSY) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {hs2_d, res_sr[WIDTH-1:1]};
      bflop  <= bnext;
      if (last_bit) begin
        // cnt stays at its last value so it never wraps.
        diff   <= {hs2_d, res_sr[WIDTH-1:1]};
        borrow <= bnext;
        busy   <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
